// File: rtl/cache_nway_ctrl_if.sv
// Bundle between the N-way cache controller and its CPU port, memory port and datapath.
// master = controller side, slave = CPU / memory / datapath side.
interface cache_nway_ctrl_if #(
    parameter int WAYS    = 4,
    parameter int S_INDEX = 3
);
    localparam int WB = $clog2(WAYS);

    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_resp;
    logic [S_INDEX-1:0]   set_index;
    logic [WAYS-1:0]      hit_vec;
    logic [WAYS-1:0]      valid_vec;
    logic [WAYS-1:0]      dirty_vec;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_resp;
    logic [WB-1:0]        way_sel;
    logic [2*WAYS-1:0]    we_sel;
    logic                 din_sel;
    logic                 addr_from_cpu;
    logic [WB-1:0]        addr_way;
    logic [WAYS-1:0]      tag_we;
    logic [WAYS-1:0]      dirty_we;
    logic                 dirty_val;

    modport master (
        input  mem_read, mem_write, set_index, hit_vec, valid_vec, dirty_vec, pmem_resp,
        output mem_resp, pmem_read, pmem_write, way_sel, we_sel, din_sel,
               addr_from_cpu, addr_way, tag_we, dirty_we, dirty_val
    );

    modport slave (
        output mem_read, mem_write, set_index, hit_vec, valid_vec, dirty_vec, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, way_sel, we_sel, din_sel,
               addr_from_cpu, addr_way, tag_we, dirty_we, dirty_val
    );
endinterface

// File: rtl/cache_nway_ctrl.sv
// Control FSM for a WAYS-way set-associative write-back cache with per-set tree pseudo-LRU
// and invalid-way-first victim selection.
module cache_nway_ctrl #(
    parameter int WAYS    = 4,
    parameter int S_INDEX = 3
) (
    input logic               clk,
    input logic               rst,
    cache_nway_ctrl_if.master bus
);
    localparam int WB    = $clog2(WAYS);
    localparam int NSETS = 2 ** S_INDEX;
    localparam int NODES = WAYS - 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t                       r_state, w_next;
    logic [WB-1:0]                r_victim;
    logic [NSETS-1:0][NODES-1:0]  r_plru;

    logic [WB-1:0]    w_victim, w_hit_way, w_inv_way;
    logic [NODES-1:0] w_tree, w_tree_upd;
    logic             w_req, w_hit, w_plru_we;

    function automatic logic [WB-1:0] lowest(input logic [WAYS-1:0] vec);
        logic [WB-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (vec[i]) idx = WB'(i);
        return idx;
    endfunction

    // Walk root to leaf; a 0 node bit sends the victim into the lower-index subtree.
    function automatic logic [WB-1:0] plru_victim(input logic [NODES-1:0] tree);
        logic [WB-1:0] node, way;
        node = '0;
        way  = '0;
        for (int l = 0; l < WB; l++) begin
            way  = WB'({way, tree[node]});
            node = tree[node] ? WB'(2 * node + 2) : WB'(2 * node + 1);
        end
        return way;
    endfunction

    function automatic logic [NODES-1:0] plru_update(input logic [NODES-1:0] tree,
                                                     input logic [WB-1:0]    w);
        logic [NODES-1:0] t;
        logic [WB-1:0]    node, path;
        logic             b;
        t    = tree;
        node = '0;
        path = w;
        for (int l = 0; l < WB; l++) begin
            b       = path[WB-1];
            t[node] = ~b;
            node    = b ? WB'(2 * node + 2) : WB'(2 * node + 1);
            path    = path << 1;
        end
        return t;
    endfunction

    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_hit      = |bus.hit_vec;
    assign w_hit_way  = lowest(bus.hit_vec);
    assign w_inv_way  = lowest(~bus.valid_vec);
    assign w_tree     = r_plru[bus.set_index];
    assign w_tree_upd = plru_update(w_tree, w_hit_way);
    assign w_victim   = (&bus.valid_vec) ? plru_victim(w_tree) : w_inv_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_victim <= '0;
            r_plru   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOOKUP && w_req && !w_hit)
                r_victim <= w_victim;
            if (w_plru_we)
                r_plru[bus.set_index] <= w_tree_upd;
        end
    end

    // Outputs are forced to their idle values while rst is high so no array write or
    // memory request escapes during the reset cycle.
    always_comb begin
        w_next            = r_state;
        w_plru_we         = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.way_sel       = '0;
        bus.we_sel        = '0;
        bus.din_sel       = 1'b0;
        bus.addr_from_cpu = 1'b1;
        bus.addr_way      = '0;
        bus.tag_we        = '0;
        bus.dirty_we      = '0;
        bus.dirty_val     = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: if (w_req) w_next = LOOKUP;
                LOOKUP: begin
                    if (!w_req) begin
                        w_next = IDLE;
                    end else if (w_hit) begin
                        bus.mem_resp = 1'b1;
                        bus.way_sel  = w_hit_way;
                        w_plru_we    = 1'b1;
                        w_next       = IDLE;
                        if (bus.mem_write) begin
                            bus.we_sel[2*w_hit_way +: 2] = 2'b10;
                            bus.dirty_we[w_hit_way]      = 1'b1;
                            bus.dirty_val                = 1'b1;
                        end
                    end else if (bus.valid_vec[w_victim] & bus.dirty_vec[w_victim]) begin
                        w_next = WRITEBACK;
                    end else begin
                        w_next = FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.addr_from_cpu = 1'b0;
                    bus.addr_way      = r_victim;
                    bus.way_sel       = r_victim;
                    if (bus.pmem_resp) w_next = FILL;
                end
                FILL: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.we_sel[2*r_victim +: 2] = 2'b01;
                        bus.din_sel                 = 1'b1;
                        bus.tag_we[r_victim]        = 1'b1;
                        bus.dirty_we[r_victim]      = 1'b1;
                        w_next                      = LOOKUP;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: a 4-way and a 2-way instance share stimulus,
// with requests steered to one instance at a time by sel2.
module tb_cache_nway_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sel2;
    logic       t_read, t_write, t_presp;
    logic [2:0] t_set;
    logic [3:0] t_hit, t_valid, t_dirty;

    int n_chk = 0;
    int n_err = 0;

    cache_nway_ctrl_if #(.WAYS(4), .S_INDEX(3)) b4();
    cache_nway_ctrl_if #(.WAYS(2), .S_INDEX(3)) b2();

    cache_nway_ctrl #(.WAYS(4), .S_INDEX(3)) u4 (.clk(clk), .rst(rst), .bus(b4.master));
    cache_nway_ctrl #(.WAYS(2), .S_INDEX(3)) u2 (.clk(clk), .rst(rst), .bus(b2.master));

    assign b4.mem_read  = t_read  & ~sel2;
    assign b4.mem_write = t_write & ~sel2;
    assign b4.set_index = t_set;
    assign b4.hit_vec   = t_hit;
    assign b4.valid_vec = t_valid;
    assign b4.dirty_vec = t_dirty;
    assign b4.pmem_resp = t_presp & ~sel2;

    assign b2.mem_read  = t_read  & sel2;
    assign b2.mem_write = t_write & sel2;
    assign b2.set_index = t_set;
    assign b2.hit_vec   = t_hit[1:0];
    assign b2.valid_vec = t_valid[1:0];
    assign b2.dirty_vec = t_dirty[1:0];
    assign b2.pmem_resp = t_presp & sel2;

    logic       o_resp, o_prd, o_pwr, o_din, o_afc, o_dval;
    logic [1:0] o_way_sel, o_addr_way;
    logic [7:0] o_we;
    logic [3:0] o_tag, o_dwe;

    always_comb begin
        if (sel2) begin
            o_resp = b2.mem_resp;  o_prd = b2.pmem_read;  o_pwr = b2.pmem_write;
            o_din  = b2.din_sel;   o_afc = b2.addr_from_cpu; o_dval = b2.dirty_val;
            o_way_sel  = {1'b0, b2.way_sel};
            o_addr_way = {1'b0, b2.addr_way};
            o_we  = {4'b0, b2.we_sel};
            o_tag = {2'b0, b2.tag_we};
            o_dwe = {2'b0, b2.dirty_we};
        end else begin
            o_resp = b4.mem_resp;  o_prd = b4.pmem_read;  o_pwr = b4.pmem_write;
            o_din  = b4.din_sel;   o_afc = b4.addr_from_cpu; o_dval = b4.dirty_val;
            o_way_sel  = b4.way_sel;
            o_addr_way = b4.addr_way;
            o_we  = b4.we_sel;
            o_tag = b4.tag_we;
            o_dwe = b4.dirty_we;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_resp"}, 32'(o_resp), 0);
        chk({tag, "_prd"},  32'(o_prd), 0);
        chk({tag, "_pwr"},  32'(o_pwr), 0);
        chk({tag, "_afc"},  32'(o_afc), 1);
        chk({tag, "_we"},   32'(o_we), 0);
        chk({tag, "_tag"},  32'(o_tag), 0);
    endtask

    task automatic do_hit(input int set, input logic [3:0] hv, input bit rd, input bit wr,
                          input int w);
        t_set = 3'(set); t_valid = sel2 ? 4'b0011 : 4'b1111; t_dirty = '0; t_hit = '0;
        t_read = rd; t_write = wr;
        settle();
        chk("hit_idle_resp", 32'(o_resp), 0);
        step();
        t_hit = hv;
        settle();
        chk("hit_resp", 32'(o_resp), 1);
        chk("hit_way_sel", 32'(o_way_sel), 32'(w));
        chk("hit_pmem", 32'({o_prd, o_pwr}), 0);
        if (wr) begin
            chk("wr_we_sel", 32'(o_we), 32'h2 << (2 * w));
            chk("wr_din_sel", 32'(o_din), 0);
            chk("wr_dirty_we", 32'(o_dwe), 32'h1 << w);
            chk("wr_dirty_val", 32'(o_dval), 1);
        end else begin
            chk("rd_we_sel", 32'(o_we), 0);
            chk("rd_dirty_we", 32'(o_dwe), 0);
        end
        step();
        t_read = 1'b0; t_write = 1'b0; t_hit = '0;
        settle();
        chk("hit_resp_pulse", 32'(o_resp), 0);
    endtask

    task automatic do_miss(input int set, input logic [3:0] valid, input logic [3:0] dirty,
                           input int v, input bit wb, input int fw, input bit drop);
        t_set = 3'(set); t_valid = valid; t_dirty = dirty; t_hit = '0;
        t_read = 1'b1; t_write = 1'b0; t_presp = 1'b0;
        settle();
        chk("miss_idle_resp", 32'(o_resp), 0);
        step();
        chk("lookup_resp", 32'(o_resp), 0);
        chk("lookup_pmem", 32'({o_prd, o_pwr}), 0);
        step();
        if (wb) begin
            chk("wb_pwr", 32'(o_pwr), 1);
            chk("wb_prd", 32'(o_prd), 0);
            chk("wb_addr_way", 32'(o_addr_way), 32'(v));
            chk("wb_way_sel", 32'(o_way_sel), 32'(v));
            chk("wb_afc", 32'(o_afc), 0);
            repeat (2) step();
            chk("wb_hold", 32'(o_pwr), 1);
            t_presp = 1'b1;
            step();
            t_presp = 1'b0;
            settle();
        end
        chk("fill_prd", 32'(o_prd), 1);
        chk("fill_pwr", 32'(o_pwr), 0);
        chk("fill_afc", 32'(o_afc), 1);
        if (drop) t_read = 1'b0;
        for (int i = 1; i < fw; i++) begin
            step();
            chk("fill_hold", 32'(o_prd), 1);
            chk("fill_no_tag", 32'(o_tag), 0);
        end
        t_presp = 1'b1;
        settle();
        chk("fill_tag_we", 32'(o_tag), 32'h1 << v);
        chk("fill_we_sel", 32'(o_we), 32'h1 << (2 * v));
        chk("fill_din_sel", 32'(o_din), 1);
        chk("fill_dirty_we", 32'(o_dwe), 32'h1 << v);
        chk("fill_dirty_val", 32'(o_dval), 0);
        step();
        t_presp = 1'b0;
        t_hit = 4'h1 << v;
        t_valid[v] = 1'b1;
        t_dirty[v] = 1'b0;
        settle();
        chk("relookup_prd", 32'(o_prd), 0);
        if (drop) begin
            chk("dropped_no_resp", 32'(o_resp), 0);
        end else begin
            chk("relookup_resp", 32'(o_resp), 1);
            chk("relookup_way", 32'(o_way_sel), 32'(v));
        end
        step();
        t_read = 1'b0; t_hit = '0;
        settle();
        chk("miss_done_resp", 32'(o_resp), 0);
        chk("miss_done_prd", 32'(o_prd), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel2 = 1'b0;
        t_read = 0; t_write = 0; t_presp = 0; t_set = '0;
        t_hit = '0; t_valid = '0; t_dirty = '0;
        repeat (2) step();
        rst = 1'b0;
        settle();
        idle_outputs("rst4");
        sel2 = 1'b1;
        settle();
        idle_outputs("rst2");
        sel2 = 1'b0;
        settle();

        // Cold set: lowest invalid way is the victim, 5-cycle fill.
        do_miss(2, 4'b0000, 4'b0000, 0, 0, 5, 0);

        // Full clean set, hits 0..3 leave the tree pointing at way 0.
        do_hit(5, 4'b0001, 1, 0, 0);
        do_hit(5, 4'b0010, 1, 0, 1);
        do_hit(5, 4'b0100, 1, 0, 2);
        do_hit(5, 4'b1000, 1, 0, 3);
        do_miss(5, 4'b1111, 4'b0000, 0, 0, 2, 0);

        // Way 0 just touched: tree now points at way 2, which is dirty.
        do_miss(5, 4'b1111, 4'b0100, 2, 1, 2, 0);

        // Write hit on way 2.
        t_set = 3'd5; t_valid = 4'b1111; t_dirty = '0; t_hit = '0; t_write = 1'b1;
        settle();
        step();
        t_hit = 4'b0100;
        settle();
        chk("wr_we_sel_const", 32'(o_we), 32'h20);
        step();
        t_write = 1'b0; t_hit = '0;
        settle();
        chk("wr_single_pulse", 32'(o_resp), 0);

        do_hit(1, 4'b0001, 1, 1, 0);
        do_hit(1, 4'b0110, 1, 0, 1);

        // Reset mid-fill of set 5 (tree would otherwise choose way 1).
        t_set = 3'd5; t_valid = 4'b1111; t_dirty = '0; t_hit = '0; t_read = 1'b1;
        settle();
        step();
        step();
        chk("pre_rst_prd", 32'(o_prd), 1);
        step();
        rst = 1'b1; t_read = 1'b0;
        step();
        rst = 1'b0;
        settle();
        idle_outputs("rst_mid_fill");
        step();
        chk("post_rst_prd", 32'(o_prd), 0);
        do_miss(5, 4'b1111, 4'b0000, 0, 0, 2, 0);

        // 2-way instance: hits 0,1,0 leave way 1 as victim; request dropped during fill.
        sel2 = 1'b1;
        settle();
        do_hit(3, 4'b0001, 1, 0, 0);
        do_hit(3, 4'b0010, 1, 0, 1);
        do_hit(3, 4'b0001, 1, 0, 0);
        do_miss(3, 4'b0011, 4'b0000, 1, 0, 3, 1);
        step();
        chk("w2_after_drop_resp", 32'(o_resp), 0);
        chk("w2_after_drop_prd", 32'(o_prd), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
